snake_game_master: RTL and testbench

- Top-level sequencer for the snake game datapath. Owns the master game FSM (idle/play/win/lose).
- Generates the one-cycle game-tick strobe that paces snake movement. Turns button presses into the registered navigation direction.
- Counts apples eaten, requests new apple positions, and declares win or loss.
- Sits between the button inputs and the snake position/drawing logic; drives its MASTER_STATE, NAVIGATION_STATE and tick inputs.

---
 rtl/snake_pkg.sv | 30 +++
 rtl/snake_tick_gen.sv | 92 +++++++++
 rtl/snake_game_master.sv | 164 ++++++++++++++++
 tb/tb_snake_game_master.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared encodings for the snake game: master-state and direction codes, and
// a helper that returns the reversal of a direction. The snake position and
// drawing datapath imports the same package so both sides agree on encodings.
package snake_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_WIN  = 2'b10,
    ST_LOSE = 2'b11
  } master_state_e;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_UP    = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_e;

  function automatic dir_e opposite_dir(input dir_e d);
    case (d)
      DIR_RIGHT: opposite_dir = DIR_LEFT;
      DIR_LEFT:  opposite_dir = DIR_RIGHT;
      DIR_UP:    opposite_dir = DIR_DOWN;
      DIR_DOWN:  opposite_dir = DIR_UP;
      default:   opposite_dir = DIR_RIGHT;
    endcase
  endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Game-tick generator. Counts clk cycles while enabled and emits a one-cycle
// registered game_tick strobe once per period; the counter is held at zero
// whenever disabled.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   en          - count enable (game in PLAY and staying there)
//   reload      - restore the period to TICK_DIV (new game)
//   speed_up    - shorten the period by DIV_STEP (apple eaten)
//   game_tick   - one-cycle strobe
// Macro SNAKE_SPEEDUP_EN: when defined, the period is a register that shrinks
// by DIV_STEP per apple down to MIN_DIV; otherwise it is the constant TICK_DIV.
module snake_tick_gen #(
  parameter int unsigned TICK_DIV = 10000000,
  parameter int unsigned MIN_DIV  = 2000000,
  parameter int unsigned DIV_STEP = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic reload,
  input  logic speed_up,
  output logic game_tick
);

  localparam int unsigned CW = $clog2(TICK_DIV + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;
  logic [CW-1:0] period;
  logic          wrap;

`ifdef SNAKE_SPEEDUP_EN
  // next_q holds the requested period; period_q only adopts it at a wrap so a
  // tick interval in progress is never cut short.
  logic [CW-1:0] period_q, period_d, next_q, next_d;

  always_comb begin
    next_d   = next_q;
    period_d = period_q;
    if (reload) begin
      next_d   = CW'(TICK_DIV);
      period_d = CW'(TICK_DIV);
    end else begin
      if (speed_up) begin
        if (32'(next_q) >= MIN_DIV + DIV_STEP) next_d = next_q - CW'(DIV_STEP);
        else                                  next_d = CW'(MIN_DIV);
      end
      if (en && wrap) period_d = next_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_q <= CW'(TICK_DIV);
      next_q   <= CW'(TICK_DIV);
    end else begin
      period_q <= period_d;
      next_q   <= next_d;
    end
  end

  assign period = period_q;
`else
  logic speed_unused;
  assign speed_unused = reload ^ speed_up ^ (MIN_DIV > DIV_STEP);
  assign period       = CW'(TICK_DIV);
`endif

  assign wrap = (cnt_q == period - 1'b1);

  always_comb begin
    cnt_d  = '0;
    tick_d = 1'b0;
    if (en) begin
      if (wrap) tick_d = 1'b1;
      else      cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign game_tick = tick_q;

endmodule

// File: rtl/snake_game_master.sv
// Master sequencer for the snake game: IDLE/PLAY/WIN/LOSE FSM, game-tick
// pacing, button-to-direction translation, apple scoring and timeout.
// Ports:
//   CLK, RESET        - clock, asynchronous active-low reset
//   BTN[3:0]          - debounced buttons: up, down, left, right
//   REACHED_TARGET    - snake head on apple (level)
//   HIT               - collision (level)
//   MASTER_STATE      - 00 idle, 01 play, 10 win, 11 lose
//   NAVIGATION_STATE  - 00 right, 01 down, 10 up, 11 left
//   GAME_TICK         - movement strobe
//   SNAKE_RESET       - return-to-origin strobe
//   APPLE_LOAD        - new apple position strobe
//   SCORE[3:0]        - apples eaten this game (saturating)
// Macro SNAKE_SPEEDUP_EN: tick period shortens with each apple (see tick gen).
module snake_game_master
  import snake_pkg::*;
#(
  parameter int unsigned TICK_DIV      = 10000000,
  parameter int unsigned WIN_SCORE     = 10,
  parameter int unsigned TIMEOUT_TICKS = 200,
  parameter int unsigned MIN_DIV       = 2000000,
  parameter int unsigned DIV_STEP      = 500000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] BTN,
  input  logic       REACHED_TARGET,
  input  logic       HIT,
  output logic [1:0] MASTER_STATE,
  output logic [1:0] NAVIGATION_STATE,
  output logic       GAME_TICK,
  output logic       SNAKE_RESET,
  output logic       APPLE_LOAD,
  output logic [3:0] SCORE
);

  master_state_e state_q, state_d;
  dir_e          nav_q, nav_d, pend_q, pend_d, press_dir;
  logic          pend_valid_q, pend_valid_d;
  logic [3:0]    score_q, score_d;
  logic [7:0]    timeout_q, timeout_d;
  logic [3:0]    btn_q;
  logic          reached_q;
  logic          snake_reset_q, snake_reset_d;
  logic          apple_load_q, apple_load_d;
  logic [3:0]    press_vec;
  logic          press, apple_edge, tick_en, reload, speed_up, game_tick;

  assign press_vec  = BTN & ~btn_q;
  assign press      = |press_vec;
  assign apple_edge = REACHED_TARGET & ~reached_q;

  always_comb begin
    if      (press_vec[3]) press_dir = DIR_UP;
    else if (press_vec[2]) press_dir = DIR_DOWN;
    else if (press_vec[1]) press_dir = DIR_LEFT;
    else                   press_dir = DIR_RIGHT;
  end

  always_comb begin
    state_d       = state_q;
    nav_d         = nav_q;
    pend_d        = pend_q;
    pend_valid_d  = pend_valid_q;
    score_d       = score_q;
    timeout_d     = timeout_q;
    snake_reset_d = 1'b0;
    apple_load_d  = 1'b0;
    reload        = 1'b0;
    speed_up      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (press) begin
          state_d       = ST_PLAY;
          score_d       = '0;
          nav_d         = DIR_RIGHT;
          pend_valid_d  = 1'b0;
          timeout_d     = '0;
          snake_reset_d = 1'b1;
          apple_load_d  = 1'b1;
          reload        = 1'b1;
        end
      end
      ST_PLAY: begin
        if (game_tick) begin
          if (pend_valid_q) nav_d = pend_q;
          pend_valid_d = 1'b0;
          if (timeout_q != '1) timeout_d = timeout_q + 8'd1;
        end
        // Reversal check uses the heading in force after this cycle's tick.
        if (press && press_dir != opposite_dir(nav_d)) begin
          pend_d       = press_dir;
          pend_valid_d = 1'b1;
        end
        if (apple_edge) begin
          if (score_q != '1) score_d = score_q + 4'd1;
          timeout_d = '0;
          speed_up  = 1'b1;
          if (32'(score_d) >= WIN_SCORE) state_d = ST_WIN;
          else                           apple_load_d = 1'b1;
        end else if (game_tick && 32'(timeout_d) >= TIMEOUT_TICKS) begin
          state_d = ST_LOSE;
        end
        if (HIT) begin
          state_d      = ST_LOSE;
          apple_load_d = 1'b0;
        end
      end
      ST_WIN, ST_LOSE: begin
        if (press) state_d = ST_IDLE;
      end
    endcase
  end

  // Counting only while PLAY persists keeps a tick from leaking into WIN/LOSE.
  assign tick_en = (state_q == ST_PLAY) && (state_d == ST_PLAY);

  snake_tick_gen #(
    .TICK_DIV (TICK_DIV),
    .MIN_DIV  (MIN_DIV),
    .DIV_STEP (DIV_STEP)
  ) u_tick_gen (
    .clk       (CLK),
    .rst_n     (RESET),
    .en        (tick_en),
    .reload    (reload),
    .speed_up  (speed_up),
    .game_tick (game_tick)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q       <= ST_IDLE;
      nav_q         <= DIR_RIGHT;
      pend_q        <= DIR_RIGHT;
      pend_valid_q  <= 1'b0;
      score_q       <= '0;
      timeout_q     <= '0;
      btn_q         <= '0;
      reached_q     <= 1'b0;
      snake_reset_q <= 1'b0;
      apple_load_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      nav_q         <= nav_d;
      pend_q        <= pend_d;
      pend_valid_q  <= pend_valid_d;
      score_q       <= score_d;
      timeout_q     <= timeout_d;
      btn_q         <= BTN;
      reached_q     <= REACHED_TARGET;
      snake_reset_q <= snake_reset_d;
      apple_load_q  <= apple_load_d;
    end
  end

  assign MASTER_STATE     = state_q;
  assign NAVIGATION_STATE = nav_q;
  assign GAME_TICK        = game_tick;
  assign SNAKE_RESET      = snake_reset_q;
  assign APPLE_LOAD       = apple_load_q;
  assign SCORE            = score_q;

endmodule

// File: tb/tb_snake_game_master.sv
// Directed bench for snake_game_master with TICK_DIV=4, WIN_SCORE=2,
// TIMEOUT_TICKS=3.
module tb_snake_game_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn;
  logic       reached;
  logic       hit;
  logic [1:0] master_state;
  logic [1:0] nav_state;
  logic       game_tick;
  logic       snake_reset;
  logic       apple_load;
  logic [3:0] score;

  int checks = 0;
  int errors = 0;
  int tick_cnt;
  int load_cnt;

  snake_game_master #(
    .TICK_DIV      (4),
    .WIN_SCORE     (2),
    .TIMEOUT_TICKS (3),
    .MIN_DIV       (2),
    .DIV_STEP      (1)
  ) dut (
    .CLK              (clk),
    .RESET            (rst_n),
    .BTN              (btn),
    .REACHED_TARGET   (reached),
    .HIT              (hit),
    .MASTER_STATE     (master_state),
    .NAVIGATION_STATE (nav_state),
    .GAME_TICK        (game_tick),
    .SNAKE_RESET      (snake_reset),
    .APPLE_LOAD       (apple_load),
    .SCORE            (score)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    rst_n = 1'b1; btn = '0; reached = 1'b0; hit = 1'b0;
    #3 rst_n = 1'b0;
    step(); step();
    chk("rst_state", 8'(master_state), 8'd0);
    chk("rst_nav",   8'(nav_state),    8'd0);
    chk("rst_score", 8'(score),        8'd0);
    chk("rst_tick",  8'(game_tick),    8'd0);
    chk("rst_sreset",8'(snake_reset),  8'd0);
    chk("rst_aload", 8'(apple_load),   8'd0);
    rst_n = 1'b1;
    step();

    // Game 1: start, steering, held apple, winning apple.
    btn = 4'b0001; step();                       // E
    chk("start_state",  8'(master_state), 8'd1);
    chk("start_sreset", 8'(snake_reset),  8'd1);
    chk("start_aload",  8'(apple_load),   8'd1);
    btn = 4'b0000; step();                       // E+1
    chk("sreset_drop",  8'(snake_reset),  8'd0);
    chk("aload_drop",   8'(apple_load),   8'd0);
    chk("tick_e1",      8'(game_tick),    8'd0);
    btn = 4'b1000; step();                       // E+2 (up pressed)
    chk("tick_e2",      8'(game_tick),    8'd0);
    btn = 4'b0010; step();                       // E+3 (left pressed, reversal)
    chk("tick_e3",      8'(game_tick),    8'd0);
    btn = 4'b0000; step();                       // E+4
    chk("first_tick",   8'(game_tick),    8'd1);
    chk("nav_before",   8'(nav_state),    8'd0);
    step();                                      // E+5
    chk("nav_up",       8'(nav_state),    8'd2);
    chk("tick_e5",      8'(game_tick),    8'd0);
    reached = 1'b1; step();                      // E+6
    chk("apple1_score", 8'(score),        8'd1);
    chk("apple1_aload", 8'(apple_load),   8'd1);
    tick_cnt = 0; load_cnt = 0;
    for (int i = 0; i < 7; i++) begin            // E+7 .. E+13
      step();
      if (game_tick)  tick_cnt++;
      if (apple_load) load_cnt++;
    end
    chk("held_ticks",   8'(tick_cnt),     8'd2);
    chk("held_aloads",  8'(load_cnt),     8'd0);
    chk("held_score",   8'(score),        8'd1);
    chk("held_state",   8'(master_state), 8'd1);
    reached = 1'b0; step();                      // E+14
    reached = 1'b1; step();                      // E+15
    chk("win_score",    8'(score),        8'd2);
    chk("win_state",    8'(master_state), 8'd2);
    chk("win_noaload",  8'(apple_load),   8'd0);
    reached = 1'b0;
    tick_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (game_tick) tick_cnt++;
    end
    chk("win_noticks",  8'(tick_cnt),     8'd0);
    chk("win_hold",     8'(master_state), 8'd2);
    chk("win_navhold",  8'(nav_state),    8'd2);
    btn = 4'b0001; step();
    chk("win_to_idle",  8'(master_state), 8'd0);
    btn = 4'b0000; step();

    // Game 2: timeout.
    btn = 4'b0001; step();                       // E'
    chk("g2_state",     8'(master_state), 8'd1);
    chk("g2_score_clr", 8'(score),        8'd0);
    chk("g2_nav_clr",   8'(nav_state),    8'd0);
    btn = 4'b0000;
    tick_cnt = 0;
    for (int i = 0; i < 12; i++) begin           // E'+1 .. E'+12
      step();
      if (game_tick) tick_cnt++;
    end
    chk("to_ticks",     8'(tick_cnt),     8'd3);
    chk("to_third",     8'(game_tick),    8'd1);
    chk("to_still_play",8'(master_state), 8'd1);
    step();                                      // E'+13
    chk("to_lose",      8'(master_state), 8'd3);
    chk("to_tick_off",  8'(game_tick),    8'd0);
    tick_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (game_tick) tick_cnt++;
    end
    chk("lose_noticks", 8'(tick_cnt),     8'd0);
    btn = 4'b0001; step();
    chk("lose_to_idle", 8'(master_state), 8'd0);
    btn = 4'b0000; step();

    // Game 3: HIT coincides with winning apple edge.
    btn = 4'b0001; step();                       // E''
    chk("g3_state",     8'(master_state), 8'd1);
    btn = 4'b0000; reached = 1'b1; step();       // E''+1
    chk("g3_score1",    8'(score),        8'd1);
    reached = 1'b0; step();                      // E''+2
    reached = 1'b1; hit = 1'b1; step();          // E''+3
    chk("hitwin_state", 8'(master_state), 8'd3);
    chk("hitwin_score", 8'(score),        8'd2);
    chk("hitwin_aload", 8'(apple_load),   8'd0);
    reached = 1'b0; hit = 1'b0;
    btn = 4'b0001; step();
    chk("g3_to_idle",   8'(master_state), 8'd0);
    btn = 4'b0000; step();

    // Game 4: asynchronous reset mid-game.
    btn = 4'b0001; step();                       // E4
    btn = 4'b0000; reached = 1'b1; step();       // E4+1
    reached = 1'b0; btn = 4'b0100; step();       // E4+2
    btn = 4'b0000; step(); step(); step();       // E4+5
    chk("g4_nav_down",  8'(nav_state),    8'd1);
    chk("g4_score",     8'(score),        8'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state",   8'(master_state), 8'd0);
    chk("arst_nav",     8'(nav_state),    8'd0);
    chk("arst_score",   8'(score),        8'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Game 5: counter cleared by reset; strobe drops asynchronously.
    btn = 4'b0001; step();                       // E5
    chk("g5_sreset",    8'(snake_reset),  8'd1);
    btn = 4'b0000;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("g5_tick", 8'(game_tick), (k == 4) ? 8'd1 : 8'd0);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tick",    8'(game_tick),    8'd0);
    chk("arst_state2",  8'(master_state), 8'd0);
    step();
    rst_n = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
